grf_writeback: RTL

GRF_WRITEBACK -- requirements
Module: grf_writeback

---
 rtl/grf_writeback_pkg.sv | 9 +
 rtl/grf_wdec.sv | 16 +
 rtl/grf_writeback.sv | 77 +++++++
 3 files changed

// File: rtl/grf_writeback_pkg.sv
// Shared constants for the general register file writeback slice.
package grf_writeback_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         NREG       = 32;
  localparam int         AW         = 5;
  localparam int         DW_DEFAULT = 32;

endpackage

// File: rtl/grf_wdec.sv
// One-hot write-address decoder; r0 is hardwired, so its select line never fires.
import grf_writeback_pkg::*;

module grf_wdec (
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
    onehot[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/grf_writeback.sv
// Two-read/one-write register file with optional write bypass, write trace and commit counter.
import grf_writeback_pkg::*;

module grf_writeback #(
  parameter int BYPASS = 1,
  parameter int DW     = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [31:0]   pc,
  output logic          trace_valid,
  output logic [31:0]   trace_pc,
  output logic [AW-1:0] trace_addr,
  output logic [DW-1:0] trace_data,
  output logic [15:0]   wr_count
);

  logic [NREG-1:0] wsel;
  logic            commit;
  logic [DW-1:0]   regs [1:NREG-1];

  grf_wdec u_wdec (
    .en     (we),
    .addr   (wa),
    .onehot (wsel)
  );

  // A write to r0 decodes to no select line, so it never commits.
  assign commit = |wsel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (wsel[i]) regs[i] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != REG_ZERO) rd1 = regs[ra1];
    if (ra2 != REG_ZERO) rd2 = regs[ra2];
    if (BYPASS != 0) begin
      if (wsel[ra1]) rd1 = wd;
      if (wsel[ra2]) rd2 = wd;
    end
  end

  // Trace payload only loads on a commit so it holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
      wr_count    <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_pc   <= pc;
        trace_addr <= wa;
        trace_data <= wd;
        wr_count   <= wr_count + 16'd1;
      end
    end
  end

endmodule
